super_mac_ctrl: RTL and testbench

Sequencing controller for the 36-tap `super_MAC` dot-product datapath. It hands out operand-issue slots to the operand fetch unit and tracks each issued vector through the MAC's fixed 3-register pipeline. It accumulates `num_passes` partial dot products per output, then saturates each finished sum and delivers it through a small result FIFO with a valid/ready handshake. It sits between the fetch unit, the `super_MAC` instance and the writeback stage.

---
 rtl/super_mac_ctrl.sv | 199 +++++++++++++++++++
 tb/tb_super_mac_ctrl.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/super_mac_ctrl.sv
// super_mac_ctrl: issue sequencer and result collector for the 36-tap
// super_MAC dot-product pipeline. Hands out operand slots, tracks each
// issued vector through the MAC's fixed latency, accumulates multi-pass
// partial sums, saturates finished sums and queues them in a credit-guarded
// result FIFO.
module super_mac_ctrl #(
    parameter int ACCUMULATOR_WIDTH = 32,
    parameter int OUTPUT_WIDTH      = 32,
    parameter int MAC_LATENCY       = 3,
    parameter int PASS_CNT_WIDTH    = 8,
    parameter int OUT_CNT_WIDTH     = 16,
    parameter int FIFO_DEPTH        = 4
) (
    input  logic                                clk,
    input  logic                                arst_n_in,
    input  logic                                start,
    input  logic [OUT_CNT_WIDTH-1:0]            num_outputs,
    input  logic [PASS_CNT_WIDTH-1:0]           num_passes,
    input  logic                                operand_valid,
    output logic                                operand_ready,
    output logic [OUT_CNT_WIDTH-1:0]            out_idx,
    output logic [PASS_CNT_WIDTH-1:0]           pass_idx,
    input  logic signed [ACCUMULATOR_WIDTH-1:0] mac_out,
    output logic signed [OUTPUT_WIDTH-1:0]      result_data,
    output logic                                result_valid,
    input  logic                                result_ready,
    output logic                                busy,
    output logic                                done
);

    localparam int CRED_W = $clog2(FIFO_DEPTH + 1);
    localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int TAIL   = MAC_LATENCY - 1;

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN} state_t;

    state_t                              state_q, state_d;
    logic [OUT_CNT_WIDTH-1:0]            cfg_outs_q;
    logic [PASS_CNT_WIDTH-1:0]           cfg_last_pass_q;
    logic [OUT_CNT_WIDTH-1:0]            out_idx_q;
    logic [PASS_CNT_WIDTH-1:0]           pass_idx_q;
    logic [CRED_W-1:0]                   credits_q;
    logic [MAC_LATENCY-1:0]              vld_q, first_q, last_q;
    logic signed [ACCUMULATOR_WIDTH-1:0] acc_q;
    logic signed [ACCUMULATOR_WIDTH-1:0] mac_sum;
    logic signed [OUTPUT_WIDTH-1:0]      sat_sum;
    logic signed [OUTPUT_WIDTH-1:0]      fifo_mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]                    wr_ptr_q, rd_ptr_q;
    logic [CRED_W-1:0]                   count_q;

    logic issue, is_last_pass, is_last_out, accept_start;
    logic push, pop, credit_take, pipe_empty, fifo_empty;

    assign accept_start = (state_q == ST_IDLE) && start;
    assign issue        = operand_valid && operand_ready;
    assign is_last_pass = (pass_idx_q == cfg_last_pass_q);
    assign is_last_out  = (out_idx_q == (cfg_outs_q - 1'b1));
    assign credit_take  = issue && is_last_pass;
    assign pop          = result_valid && result_ready;
    assign push         = vld_q[TAIL] && last_q[TAIL];
    assign pipe_empty   = ~|vld_q;
    assign fifo_empty   = (count_q == '0);

    assign out_idx      = out_idx_q;
    assign pass_idx     = pass_idx_q;
    assign result_valid = !fifo_empty;
    assign result_data  = fifo_mem_q[rd_ptr_q];

    // State register
    always_ff @(posedge clk or negedge arst_n_in) begin
        if (!arst_n_in) state_q <= ST_IDLE;
        else            state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (start) state_d = (num_outputs == '0) ? ST_DRAIN : ST_RUN;
            ST_RUN:   if (issue && is_last_pass && is_last_out) state_d = ST_DRAIN;
            ST_DRAIN: if (pipe_empty && fifo_empty) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Outputs: a last-pass issue needs a credit so the FIFO can never overflow
    always_comb begin
        operand_ready = 1'b0;
        busy          = (state_q != ST_IDLE);
        done          = 1'b0;
        case (state_q)
            ST_RUN:   operand_ready = !is_last_pass || (credits_q != '0);
            ST_DRAIN: done = pipe_empty && fifo_empty;
            default:  ;
        endcase
    end

    // Job configuration and issue counters; num_passes==0 behaves as 1
    always_ff @(posedge clk or negedge arst_n_in) begin
        if (!arst_n_in) begin
            cfg_outs_q      <= '0;
            cfg_last_pass_q <= '0;
            out_idx_q       <= '0;
            pass_idx_q      <= '0;
        end else if (accept_start) begin
            cfg_outs_q      <= num_outputs;
            cfg_last_pass_q <= (num_passes == '0) ? '0 : num_passes - 1'b1;
            out_idx_q       <= '0;
            pass_idx_q      <= '0;
        end else if (issue) begin
            if (is_last_pass) begin
                pass_idx_q <= '0;
                out_idx_q  <= out_idx_q + 1'b1;
            end else begin
                pass_idx_q <= pass_idx_q + 1'b1;
            end
        end
    end

    // Credits: one per FIFO slot, reserved at last-pass issue, returned on pop
    always_ff @(posedge clk or negedge arst_n_in) begin
        if (!arst_n_in)                 credits_q <= CRED_W'(FIFO_DEPTH);
        else if (credit_take && !pop)   credits_q <= credits_q - 1'b1;
        else if (pop && !credit_take)   credits_q <= credits_q + 1'b1;
    end

    // Valid pipe head: captures each issue alongside the MAC's first register
    always_ff @(posedge clk or negedge arst_n_in) begin
        if (!arst_n_in) begin
            vld_q[0]   <= 1'b0;
            first_q[0] <= 1'b0;
            last_q[0]  <= 1'b0;
        end else begin
            vld_q[0]   <= issue;
            first_q[0] <= issue && (pass_idx_q == '0);
            last_q[0]  <= issue && is_last_pass;
        end
    end

    generate
        for (genvar gi = 1; gi < MAC_LATENCY; gi++) begin : g_pipe
            // Remaining pipe stages shift unconditionally, as the MAC cannot stall
            always_ff @(posedge clk or negedge arst_n_in) begin
                if (!arst_n_in) begin
                    vld_q[gi]   <= 1'b0;
                    first_q[gi] <= 1'b0;
                    last_q[gi]  <= 1'b0;
                end else begin
                    vld_q[gi]   <= vld_q[gi-1];
                    first_q[gi] <= first_q[gi-1];
                    last_q[gi]  <= last_q[gi-1];
                end
            end
        end
    endgenerate

    // Partial sum for the entry aligned with mac_out (wraps at accumulator width)
    assign mac_sum = first_q[TAIL] ? mac_out : acc_q + mac_out;

    generate
        if (OUTPUT_WIDTH == ACCUMULATOR_WIDTH) begin : g_nosat
            assign sat_sum = mac_sum;
        end else begin : g_sat
            logic [ACCUMULATOR_WIDTH-OUTPUT_WIDTH:0] upper;
            logic                                    fits;
            assign upper   = mac_sum[ACCUMULATOR_WIDTH-1:OUTPUT_WIDTH-1];
            assign fits    = (&upper) || !(|upper);
            assign sat_sum = fits ? mac_sum[OUTPUT_WIDTH-1:0]
                           : (mac_sum[ACCUMULATOR_WIDTH-1] ? {1'b1, {(OUTPUT_WIDTH-1){1'b0}}}
                                                           : {1'b0, {(OUTPUT_WIDTH-1){1'b1}}});
        end
    endgenerate

    // Accumulator tracks the running sum of the output currently at the tail
    always_ff @(posedge clk or negedge arst_n_in) begin
        if (!arst_n_in)        acc_q <= '0;
        else if (vld_q[TAIL])  acc_q <= mac_sum;
    end

    // Result FIFO; credits make a push into a full FIFO impossible
    always_ff @(posedge clk or negedge arst_n_in) begin
        if (!arst_n_in) begin
            for (int i = 0; i < FIFO_DEPTH; i++) fifo_mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                fifo_mem_q[wr_ptr_q] <= sat_sum;
                wr_ptr_q <= (wr_ptr_q == PTR_W'(FIFO_DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
            end
            if (pop)
                rd_ptr_q <= (rd_ptr_q == PTR_W'(FIFO_DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
            if (push && !pop)      count_q <= count_q + 1'b1;
            else if (pop && !push) count_q <= count_q - 1'b1;
        end
    end

endmodule

// File: tb/tb_super_mac_ctrl.sv
// Testbench for super_mac_ctrl. A behavioural 3-stage delay line stands in
// for super_MAC; expected results go into a scoreboard queue that a forked
// monitor drains on every FIFO pop.
module tb_super_mac_ctrl;

    localparam int AW  = 32;
    localparam int OW  = 16;
    localparam int PW  = 8;
    localparam int OCW = 16;
    localparam int FD  = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 arst_n_in, start, operand_valid, operand_ready;
    logic [OCW-1:0]       num_outputs, out_idx;
    logic [PW-1:0]        num_passes, pass_idx;
    logic signed [AW-1:0] mac_out, cur_partial, s1, s2, s3;
    logic signed [OW-1:0] result_data;
    logic                 result_valid, result_ready, busy, done;

    super_mac_ctrl #(
        .ACCUMULATOR_WIDTH(AW), .OUTPUT_WIDTH(OW), .MAC_LATENCY(3),
        .PASS_CNT_WIDTH(PW), .OUT_CNT_WIDTH(OCW), .FIFO_DEPTH(FD)
    ) dut (
        .clk(clk), .arst_n_in(arst_n_in), .start(start),
        .num_outputs(num_outputs), .num_passes(num_passes),
        .operand_valid(operand_valid), .operand_ready(operand_ready),
        .out_idx(out_idx), .pass_idx(pass_idx), .mac_out(mac_out),
        .result_data(result_data), .result_valid(result_valid),
        .result_ready(result_ready), .busy(busy), .done(done)
    );

    // MAC model: the partial presented in cycle c appears on mac_out in c+3
    always @(posedge clk) begin
        s1 <= cur_partial;
        s2 <= s1;
        s3 <= s2;
    end
    assign mac_out = s3;

    int total = 0;
    int bad   = 0;
    logic signed [OW-1:0]    exp_q [$];
    logic signed [AW-1:0]    part_q[$];
    logic [OCW+PW-1:0]       idx_q [$];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input longint act, input longint req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    task automatic monitor();
        logic signed [OW-1:0] e;
        forever begin
            @(negedge clk);
            if (arst_n_in && result_valid && result_ready) begin
                $display("pop result=%0d", result_data);
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_result: got %0d, expected none", result_data);
                end else begin
                    e = exp_q.pop_front();
                    check("result", result_data, e);
                end
            end
        end
    endtask

    task automatic start_job(input int nout, input int npass);
        num_outputs = OCW'(nout);
        num_passes  = PW'(npass);
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic drive_issues(input int max_cycles, output int n_issued);
        int   k;
        logic iss;
        n_issued = 0;
        k = 0;
        while (part_q.size() > 0 && k < max_cycles) begin
            cur_partial   = part_q[0];
            operand_valid = 1'b1;
            iss = operand_ready;
            if (iss) begin
                $display("issue out=%0d pass=%0d partial=%0d", out_idx, pass_idx, cur_partial);
                if (idx_q.size() > 0) check("issue_idx", {out_idx, pass_idx}, idx_q.pop_front());
            end
            step();
            if (iss) begin
                void'(part_q.pop_front());
                n_issued++;
            end
            k++;
        end
        operand_valid = 1'b0;
        cur_partial   = '0;
    endtask

    task automatic wait_done(input int max_cycles);
        int k;
        k = 0;
        while (!done && k < max_cycles) begin
            step();
            k++;
        end
        check("done_seen", done, 1);
        check("all_results_out", exp_q.size(), 0);
        step();
        check("busy_after_done", busy, 0);
        check("done_one_cycle", done, 0);
    endtask

    initial begin
        int n;
        arst_n_in = 1'b0; start = 1'b0; operand_valid = 1'b0; result_ready = 1'b1;
        cur_partial = '0; num_outputs = '0; num_passes = '0;
        fork
            monitor();
        join_none
        repeat (3) @(posedge clk);
        #1;
        check("rst_operand_ready", operand_ready, 0);
        check("rst_out_idx", out_idx, 0);
        check("rst_pass_idx", pass_idx, 0);
        check("rst_result_data", result_data, 0);
        check("rst_result_valid", result_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        arst_n_in = 1'b1;
        step();

        // Test 1: single output, exact latency
        result_ready = 1'b0;
        exp_q.push_back(16'sd100);
        start_job(1, 1);
        check("t1_busy_c1", busy, 1);
        check("t1_ready_c1", operand_ready, 1);
        operand_valid = 1'b1;
        cur_partial   = 100;
        $display("issue out=%0d pass=%0d partial=%0d", out_idx, pass_idx, cur_partial);
        step();
        operand_valid = 1'b0;
        cur_partial   = '0;
        step();
        step();
        check("t1_valid_c4", result_valid, 0);
        step();
        check("t1_valid_c5", result_valid, 1);
        result_ready = 1'b1;
        step();
        check("t1_done_c6", done, 1);
        step();
        check("t1_done_c7", done, 0);
        check("t1_busy_c7", busy, 0);

        // Test 2: three passes accumulate 10 - 3 + 7
        exp_q.push_back(16'sd14);
        part_q = '{32'sd10, -32'sd3, 32'sd7};
        idx_q  = '{{16'd0, 8'd0}, {16'd0, 8'd1}, {16'd0, 8'd2}};
        start_job(1, 3);
        drive_issues(10, n);
        check("t2_issues", n, 3);
        wait_done(20);

        // Test 3: backpressure limits issues to the FIFO depth
        result_ready = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            exp_q.push_back(OW'(i));
            part_q.push_back(AW'(i));
            idx_q.push_back({OCW'(i - 1), 8'd0});
        end
        start_job(6, 1);
        drive_issues(12, n);
        check("t3_issues_blocked", n, 4);
        check("t3_ready_low", operand_ready, 0);
        check("t3_result_valid", result_valid, 1);
        result_ready = 1'b1;
        drive_issues(20, n);
        check("t3_issues_rest", n, 2);
        wait_done(30);

        // Test 4: saturation to 16 bits in both directions
        exp_q.push_back(16'sd32767);
        exp_q.push_back(-16'sd32768);
        part_q = '{32'sd30000, 32'sd30000, -32'sd30000, -32'sd30000};
        start_job(2, 2);
        drive_issues(10, n);
        check("t4_issues", n, 4);
        wait_done(20);

        // Test 5a: empty job
        start_job(0, 5);
        check("t5_done_c1", done, 1);
        step();
        check("t5_done_c2", done, 0);
        check("t5_busy_c2", busy, 0);

        // Test 5b: start during RUN is ignored
        exp_q.push_back(16'sd11);
        exp_q.push_back(16'sd15);
        part_q = '{32'sd5, 32'sd6, 32'sd7, 32'sd8};
        idx_q  = '{{16'd0, 8'd0}, {16'd0, 8'd1}, {16'd1, 8'd0}, {16'd1, 8'd1}};
        start_job(2, 2);
        drive_issues(1, n);
        check("t5_first_issue", n, 1);
        num_outputs = '0;
        num_passes  = 8'd1;
        start = 1'b1;
        step();
        start = 1'b0;
        check("t5_out_idx_kept", out_idx, 0);
        check("t5_pass_idx_kept", pass_idx, 1);
        check("t5_busy_kept", busy, 1);
        drive_issues(10, n);
        check("t5_issues_rest", n, 3);
        wait_done(20);

        // Test 6: asynchronous reset with two vectors in flight
        part_q = '{32'sd1, 32'sd2, 32'sd3};
        start_job(3, 1);
        drive_issues(2, n);
        check("t6_issues", n, 2);
        part_q.delete();
        #3;
        arst_n_in = 1'b0;
        #1;
        check("t6_rst_operand_ready", operand_ready, 0);
        check("t6_rst_out_idx", out_idx, 0);
        check("t6_rst_busy", busy, 0);
        check("t6_rst_result_valid", result_valid, 0);
        check("t6_rst_result_data", result_data, 0);
        check("t6_rst_done", done, 0);
        step();
        step();
        arst_n_in = 1'b1;
        repeat (10) step();
        check("t6_no_result", result_valid, 0);
        check("t6_idle", busy, 0);
        result_ready = 1'b0;
        for (int i = 11; i <= 14; i++) begin
            exp_q.push_back(OW'(i));
            part_q.push_back(AW'(i));
        end
        start_job(4, 1);
        drive_issues(8, n);
        check("t6_full_credits", n, 4);
        result_ready = 1'b1;
        wait_done(20);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
